ex_muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit for the execution stage, parametrised in operand width. It takes already-forwarded operands and a funct3 code from EX, holds the pipeline via `md_stall` while it iterates, and returns one result word for the MA-stage register. It adds multi-cycle M-extension arithmetic alongside the existing single-cycle ALU. Pipeline flush (`rst_pipe`) aborts any operation in flight.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_iter_core.sv | 64 ++++++
 rtl/ex_muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and decode helpers for the M-extension multiply/divide unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_code_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

   function automatic logic md_is_div(input md_code_t c);
      return c inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic md_rs1_signed(input md_code_t c);
      return c inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic md_rs2_signed(input md_code_t c);
      return c inside {MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// One-step-per-cycle shift/add (multiply) or shift/subtract (restoring divide) datapath.
// acc holds product high half / partial remainder, lo holds product low half / quotient.
module md_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            mode_div,
   input  logic [XLEN-1:0] acc_in,
   input  logic [XLEN-1:0] lo_in,
   input  logic [XLEN-1:0] b_in,
   output logic [XLEN-1:0] acc_out,
   output logic [XLEN-1:0] lo_out
);

   logic [XLEN-1:0] acc, lo, b;
   logic [XLEN:0]   opa, opb, sum;
   logic [XLEN-1:0] acc_nxt, lo_nxt;

   // Divide uses the guard bit as the borrow: a set MSB means the trial subtract failed.
   always_comb begin
      if (mode_div) begin
         opa = {acc, lo[XLEN-1]};
         opb = ~{1'b0, b};
      end else begin
         opa = {1'b0, acc};
         opb = lo[0] ? {1'b0, b} : '0;
      end
      sum = opa + opb + {{XLEN{1'b0}}, mode_div};
      if (mode_div) begin
         if (sum[XLEN]) begin
            acc_nxt = opa[XLEN-1:0];
            lo_nxt  = {lo[XLEN-2:0], 1'b0};
         end else begin
            acc_nxt = sum[XLEN-1:0];
            lo_nxt  = {lo[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_nxt = sum[XLEN:1];
         lo_nxt  = {sum[0], lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         lo  <= '0;
         b   <= '0;
      end else if (load) begin
         acc <= acc_in;
         lo  <= lo_in;
         b   <= b_in;
      end else if (step) begin
         acc <= acc_nxt;
         lo  <= lo_nxt;
      end
   end

   assign acc_out = acc;
   assign lo_out  = lo;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for EX; stalls the pipe while iterating.
// Optional MD_FAST_MUL_EN: single-cycle combinational multiply, CALC kept for divide only.
//
// state | meaning
// IDLE  | waiting for start_ex; operands latched and preloaded on accept
// CALC  | one multiply/divide step per cycle, counter counts XLEN down to 0
// FIX   | sign correction and result select, result registered
// DONE  | md_valid strobe, stall released
module ex_muldiv_unit
   import md_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_ex,
   input  logic [2:0]      md_code_ex,
   input  logic [XLEN-1:0] rs1_sel,
   input  logic [XLEN-1:0] rs2_sel,
   input  logic            rst_pipe,
   output logic            md_busy,
   output logic            md_stall,
   output logic            md_valid,
   output logic [XLEN-1:0] md_result
);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   md_code_t         code_q;
   logic             neg_res, neg_rem, raw;

   md_code_t         code_in;
   logic             s1, s2, div0, ovf, fast, accept;
   logic [XLEN-1:0]  a_mag, b_mag, acc_ld, lo_ld;
   logic [XLEN-1:0]  acc_q, lo_q;
   logic [2*XLEN-1:0] prod, prod_c;
   logic [XLEN-1:0]  quo_c, rem_c, fix_result;

   assign code_in = md_code_t'(md_code_ex);
   assign s1      = md_rs1_signed(code_in) & rs1_sel[XLEN-1];
   assign s2      = md_rs2_signed(code_in) & rs2_sel[XLEN-1];
   assign a_mag   = s1 ? -rs1_sel : rs1_sel;
   assign b_mag   = s2 ? -rs2_sel : rs2_sel;
   assign div0    = md_is_div(code_in) && (rs2_sel == '0);
   assign ovf     = (code_in == MD_DIV || code_in == MD_REM)
                    && (rs1_sel == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_sel == '1);
   assign accept  = (state == MD_IDLE) && start_ex && !rst_pipe;

`ifdef MD_FAST_MUL_EN
   logic signed [XLEN:0]     fm_a, fm_b;
   logic signed [2*XLEN+1:0] fm_p;
   assign fm_a = {md_rs1_signed(code_in) & rs1_sel[XLEN-1], rs1_sel};
   assign fm_b = {md_rs2_signed(code_in) & rs2_sel[XLEN-1], rs2_sel};
   assign fm_p = fm_a * fm_b;
   assign fast = !md_is_div(code_in);
`else
   assign fast = 1'b0;
`endif

   // Special cases and the fast product are loaded as final values and bypass sign fix.
   always_comb begin
      acc_ld = '0;
      lo_ld  = a_mag;
      if (div0) begin
         acc_ld = rs1_sel;
         lo_ld  = '1;
      end else if (ovf) begin
         acc_ld = '0;
         lo_ld  = rs1_sel;
      end
`ifdef MD_FAST_MUL_EN
      else if (fast) begin
         acc_ld = fm_p[2*XLEN-1:XLEN];
         lo_ld  = fm_p[XLEN-1:0];
      end
`endif
   end

   md_iter_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .step     (state == MD_CALC),
      .mode_div (md_is_div(code_q)),
      .acc_in   (acc_ld),
      .lo_in    (lo_ld),
      .b_in     (b_mag),
      .acc_out  (acc_q),
      .lo_out   (lo_q)
   );

   always_comb begin
      prod       = {acc_q, lo_q};
      prod_c     = (neg_res && !raw) ? -prod : prod;
      quo_c      = (neg_res && !raw) ? -lo_q : lo_q;
      rem_c      = (neg_rem && !raw) ? -acc_q : acc_q;
      fix_result = rem_c;
      case (code_q)
         MD_MUL:                       fix_result = prod_c[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_c[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_result = quo_c;
         default:                      fix_result = rem_c;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= MD_IDLE;
         cnt       <= '0;
         code_q    <= MD_MUL;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         raw       <= 1'b0;
         md_valid  <= 1'b0;
         md_result <= '0;
      end else if (rst_pipe) begin
         state    <= MD_IDLE;
         md_valid <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               md_valid <= 1'b0;
               if (start_ex) begin
                  code_q  <= code_in;
                  neg_res <= s1 ^ s2;
                  neg_rem <= s1;
                  cnt     <= CNT_W'(XLEN);
                  raw     <= div0 | ovf | fast;
                  state   <= (div0 | ovf | fast) ? MD_FIX : MD_CALC;
               end
            end
            MD_CALC: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= MD_FIX;
            end
            MD_FIX: begin
               md_result <= fix_result;
               md_valid  <= 1'b1;
               state     <= MD_DONE;
            end
            default: begin
               md_valid <= 1'b0;
               state    <= MD_IDLE;
            end
         endcase
      end
   end

   assign md_busy  = (state != MD_IDLE);
   assign md_stall = (start_ex && state == MD_IDLE) || state == MD_CALC || state == MD_FIX;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed self-checking bench for ex_muldiv_unit against an arithmetic model.
module tb_ex_muldiv_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n, start_ex, rst_pipe;
   logic [2:0]      md_code_ex;
   logic [XLEN-1:0] rs1_sel, rs2_sel;
   logic            md_busy, md_stall, md_valid;
   logic [XLEN-1:0] md_result;

   int              n_vec = 0;
   int              n_err = 0;
   logic [31:0]     last_res;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_ex   (start_ex),
      .md_code_ex (md_code_ex),
      .rs1_sel    (rs1_sel),
      .rs2_sel    (rs2_sel),
      .rst_pipe   (rst_pipe),
      .md_busy    (md_busy),
      .md_stall   (md_stall),
      .md_valid   (md_valid),
      .md_result  (md_result)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (c)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      bit is_div;
      is_div = c[2];
`ifdef MD_FAST_MUL_EN
      if (!is_div) return 2;
`endif
      if (is_div && b == 0) return 2;
      if ((c == 3'd4 || c == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return XLEN + 2;
   endfunction

   // Entered just after a rising edge; starts the op in this cycle and returns one cycle after DONE.
   task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
      logic [31:0] exp_res;
      logic [31:0] res_v;
      int          lat, vcyc, vcnt, bad_stall, bad_busy;
      exp_res   = ref_md(c, a, b);
      lat       = exp_lat(c, a, b);
      vcyc      = -1;
      vcnt      = 0;
      bad_stall = 0;
      bad_busy  = 0;
      res_v     = '0;
      md_code_ex = c;
      rs1_sel    = a;
      rs2_sel    = b;
      start_ex   = 1'b1;
      for (int n = 0; n <= lat; n++) begin
         @(negedge clk);
         if (n == 0) chk("held", {32'd0, md_result}, {32'd0, last_res});
         if (md_stall !== (n < lat)) bad_stall++;
         if (md_busy !== (n >= 1)) bad_busy++;
         if (md_valid === 1'b1) begin
            if (vcyc < 0) begin
               vcyc  = n;
               res_v = md_result;
            end
            vcnt++;
         end
         @(posedge clk);
         #1;
         if (poke && n == 2 && lat > 5) begin
            start_ex   = 1'b1;
            md_code_ex = 3'($urandom_range(0, 7));
            rs1_sel    = $urandom;
            rs2_sel    = $urandom;
         end else begin
            start_ex = 1'b0;
         end
      end
      chk($sformatf("valid_cyc c%0d", c), 64'(vcyc), 64'(lat));
      chk($sformatf("valid_cnt c%0d", c), 64'(vcnt), 64'd1);
      chk($sformatf("stall c%0d", c), 64'(bad_stall), 64'd0);
      chk($sformatf("busy c%0d", c), 64'(bad_busy), 64'd0);
      chk($sformatf("result c%0d a=%0h b=%0h", c, a, b), {32'd0, res_v}, {32'd0, exp_res});
      last_res = exp_res;
   endtask

   initial begin
      int abort_valid;
      logic [2:0]  c;
      logic [31:0] a, b;
      rst_n      = 1'b0;
      start_ex   = 1'b0;
      rst_pipe   = 1'b0;
      md_code_ex = 3'd0;
      rs1_sel    = '0;
      rs2_sel    = '0;
      last_res   = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy",  {63'd0, md_busy},  64'd0);
      chk("rst_stall", {63'd0, md_stall}, 64'd0);
      chk("rst_valid", {63'd0, md_valid}, 64'd0);
      chk("rst_result", {32'd0, md_result}, 64'd0);
      @(posedge clk);
      #1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 1'b0);
      run_op(3'd5, 32'd5, 32'd0, 1'b0);
      run_op(3'd6, 32'd5, 32'd0, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd0, 32'h1234_5678, 32'h10, 1'b0);

      // Flush a DIV in cycle 10; the MUL that follows starts in cycle 11.
      abort_valid = 0;
      md_code_ex = 3'd4;
      rs1_sel    = 32'd1000;
      rs2_sel    = 32'd3;
      start_ex   = 1'b1;
      for (int n = 0; n <= 10; n++) begin
         if (n == 10) rst_pipe = 1'b1;
         @(negedge clk);
         if (md_valid === 1'b1) abort_valid++;
         @(posedge clk);
         #1;
         start_ex = 1'b0;
         rst_pipe = 1'b0;
      end
      chk("abort_valid", 64'(abort_valid), 64'd0);
      run_op(3'd0, 32'd12345, 32'd678, 1'b0);

      for (int i = 0; i < 40; i++) begin
         c = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         run_op(c, a, b, 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("final_held", {32'd0, md_result}, {32'd0, last_res});
      chk("final_busy", {63'd0, md_busy}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
